// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the synchronous data memory.
package dmem_pkg;

  localparam int NBITS_A_DEFAULT = 11;
  localparam int NBITS_D_DEFAULT = 16;
  localparam int CELDAS_DEFAULT  = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled single-port RAM: read-first, registered read data, contents
// start as cell k = k and survive reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int NBITS_A = NBITS_A_DEFAULT,
  parameter  int NBITS_D = NBITS_D_DEFAULT,
  parameter  int CELDAS  = CELDAS_DEFAULT,
  localparam int NBYTES  = NBITS_D / 8
) (
  input  logic               clk,
  input  logic               rd_en,
  input  logic [NBYTES-1:0]  we,
  input  logic [NBITS_A-1:0] addr,
  input  logic [NBITS_D-1:0] wdata,
  output logic [NBITS_D-1:0] q
);

  localparam int IW = (CELDAS > 1) ? $clog2(CELDAS) : 1;

  typedef logic [NBITS_D-1:0] mem_t [CELDAS];

  function automatic mem_t init_mem();
    mem_t m;
    for (int k = 0; k < CELDAS; k++) begin
      m[k] = NBITS_D'(k);
    end
    return m;
  endfunction

  mem_t mem = init_mem();

  // Callers only enable the array for in-range addresses, so the low bits suffice.
  logic [IW-1:0] idx;
  assign idx = addr[IW-1:0];

  always_ff @(posedge clk) begin
    if (rd_en) begin
      q <= mem[idx];
    end
    for (int k = 0; k < NBYTES; k++) begin
      if (we[k]) begin
        mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/data_memory_sync.sv
// Synchronous data memory for the pipelined CPU: registered reads, byte-lane
// writes, address range checking and a post-halt dump engine.
module data_memory_sync
  import dmem_pkg::*;
#(
  parameter  int NBITS_A = NBITS_A_DEFAULT,
  parameter  int NBITS_D = NBITS_D_DEFAULT,
  parameter  int CELDAS  = CELDAS_DEFAULT,
  localparam int NBYTES  = NBITS_D / 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rd,
  input  logic               i_wr,
  input  logic [NBITS_A-1:0] i_addr,
  input  logic [NBITS_D-1:0] i_wdata,
  input  logic [NBYTES-1:0]  i_be,
  output logic [NBITS_D-1:0] o_rdata,
  output logic               o_addr_err,
  output logic               o_busy,
  input  logic               i_dump_start,
  output logic               o_dump_valid,
  input  logic               i_dump_ready,
  output logic [NBITS_D-1:0] o_dump_data,
  output logic [NBITS_A-1:0] o_dump_addr,
  output logic               o_dump_done
);

  localparam logic [NBITS_A:0]   CELDAS_W = (NBITS_A + 1)'(CELDAS);
  localparam logic [NBITS_A-1:0] LAST     = NBITS_A'(CELDAS - 1);

  dmem_state_e        state_q;
  logic [NBITS_A-1:0] cnt_q;
  logic               in_range, cpu_ok, cpu_rd, cpu_wr, arr_rd;
  logic [NBYTES-1:0]  arr_we;
  logic [NBITS_A-1:0] arr_addr;
  logic [NBITS_D-1:0] arr_q;
  logic               cpu_sel_q;
  logic [NBITS_D-1:0] rdata_hold_q;
  logic               addr_err_q;

  assign in_range = {1'b0, i_addr} < CELDAS_W;
  // A dump start wins over a CPU access in the same cycle.
  assign cpu_ok   = !i_reset && (state_q == IDLE) && !i_dump_start;
  assign cpu_rd   = cpu_ok && i_rd;
  assign cpu_wr   = cpu_ok && i_wr;
  assign arr_rd   = !i_reset && ((cpu_rd && in_range) || (state_q == READ));
  assign arr_we   = (cpu_wr && in_range) ? i_be : '0;
  assign arr_addr = (state_q == READ) ? cnt_q : i_addr;

  dmem_array #(
    .NBITS_A (NBITS_A),
    .NBITS_D (NBITS_D),
    .CELDAS  (CELDAS)
  ) u_array (
    .clk   (i_clk),
    .rd_en (arr_rd),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (i_wdata),
    .q     (arr_q)
  );

  // Dump handshake: a word transfers on a rising edge where o_dump_valid and
  // i_dump_ready are both high; data/addr hold steady while valid waits on ready.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_dump_start) begin
          cnt_q   <= '0;
          state_q <= READ;
        end
        READ: state_q <= SEND;
        SEND: if (i_dump_ready) begin
          if (cnt_q == LAST) begin
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= READ;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The array register is shared with the dump path, so the last CPU result is
  // parked in rdata_hold_q whenever a dump read is about to overwrite it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cpu_sel_q    <= 1'b0;
      rdata_hold_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      addr_err_q <= (cpu_rd || cpu_wr) && !in_range;
      if (cpu_rd && in_range) begin
        cpu_sel_q <= 1'b1;
      end else if (cpu_rd) begin
        cpu_sel_q    <= 1'b0;
        rdata_hold_q <= '0;
      end else if (state_q == READ) begin
        cpu_sel_q    <= 1'b0;
        rdata_hold_q <= o_rdata;
      end
    end
  end

  assign o_rdata      = cpu_sel_q ? arr_q : rdata_hold_q;
  assign o_addr_err   = addr_err_q;
  assign o_busy       = (state_q != IDLE);
  assign o_dump_valid = (state_q == SEND);
  assign o_dump_data  = (state_q == SEND) ? arr_q : '0;
  assign o_dump_addr  = (state_q == SEND) ? cnt_q : '0;
  assign o_dump_done  = (state_q == DONE);

endmodule

// File: tb/tb_data_memory_sync.sv
// Bench for data_memory_sync: directed scenarios plus random CPU traffic and
// dump streams, all checked against an array-based model of the memory.
module tb_data_memory_sync;

  localparam int NA = 11;
  localparam int ND = 16;
  localparam int NC = 512;
  localparam int NB = ND / 8;

  logic          i_clk, i_reset, i_rd, i_wr;
  logic [NA-1:0] i_addr;
  logic [ND-1:0] i_wdata;
  logic [NB-1:0] i_be;
  logic [ND-1:0] o_rdata;
  logic          o_addr_err, o_busy, i_dump_start, o_dump_valid, i_dump_ready;
  logic [ND-1:0] o_dump_data;
  logic [NA-1:0] o_dump_addr;
  logic          o_dump_done;

  data_memory_sync #(.NBITS_A(NA), .NBITS_D(ND), .CELDAS(NC)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rd         (i_rd),
    .i_wr         (i_wr),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_be         (i_be),
    .o_rdata      (o_rdata),
    .o_addr_err   (o_addr_err),
    .o_busy       (o_busy),
    .i_dump_start (i_dump_start),
    .o_dump_valid (o_dump_valid),
    .i_dump_ready (i_dump_ready),
    .o_dump_data  (o_dump_data),
    .o_dump_addr  (o_dump_addr),
    .o_dump_done  (o_dump_done)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [ND-1:0] model_mem [2**NA];
  logic [ND-1:0] exp_rdata;
  logic          exp_err;

  task automatic model_access(input logic rd, input logic wr, input logic [NA-1:0] addr,
                              input logic [ND-1:0] wdata, input logic [NB-1:0] be);
    exp_err = (rd || wr) && (int'(addr) >= NC);
    if (int'(addr) < NC) begin
      if (rd) exp_rdata = model_mem[addr];
      if (wr) begin
        for (int k = 0; k < NB; k++) begin
          if (be[k]) model_mem[addr][8*k +: 8] = wdata[8*k +: 8];
        end
      end
    end else if (rd) begin
      exp_rdata = '0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cpu(input logic rd, input logic wr, input logic [NA-1:0] addr,
                           input logic [ND-1:0] wdata, input logic [NB-1:0] be);
    @(negedge i_clk);
    i_rd = rd; i_wr = wr; i_addr = addr; i_wdata = wdata; i_be = be;
    i_dump_start = 1'b0;
    @(posedge i_clk);
    #1;
    i_rd = 1'b0; i_wr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (o_rdata !== '0)      begin errors++; $display("FAIL reset_rdata got %h exp 0", o_rdata); end
    checks++; if (o_addr_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", o_addr_err); end
    checks++; if (o_busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if (o_dump_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_dump_valid); end
    checks++; if (o_dump_data !== '0)  begin errors++; $display("FAIL reset_ddata got %h exp 0", o_dump_data); end
    checks++; if (o_dump_addr !== '0)  begin errors++; $display("FAIL reset_daddr got %h exp 0", o_dump_addr); end
    checks++; if (o_dump_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", o_dump_done); end
    @(negedge i_clk);
    i_reset = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic test_powerup;
    model_access(1'b1, 1'b0, 11'd5, '0, '0);
    drive_cpu(1'b1, 1'b0, 11'd5, '0, '0);
    checks++; if (o_rdata !== 16'h0005) begin errors++; $display("FAIL powerup_read got %h exp 0005", o_rdata); end
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    exp_rdata = '0;
    checks++; if (o_rdata !== 16'h0000) begin errors++; $display("FAIL reset_clears_rdata got %h exp 0000", o_rdata); end
    model_access(1'b1, 1'b0, 11'd5, '0, '0);
    drive_cpu(1'b1, 1'b0, 11'd5, '0, '0);
    checks++; if (o_rdata !== 16'h0005) begin errors++; $display("FAIL reset_keeps_cell got %h exp 0005", o_rdata); end
  endtask

  task automatic test_byte_write;
    model_access(1'b0, 1'b1, 11'd3, 16'hABCD, 2'b10);
    drive_cpu(1'b0, 1'b1, 11'd3, 16'hABCD, 2'b10);
    model_access(1'b1, 1'b0, 11'd3, '0, '0);
    drive_cpu(1'b1, 1'b0, 11'd3, '0, '0);
    checks++; if (o_rdata !== 16'hAB03) begin errors++; $display("FAIL byte_hi got %h exp AB03", o_rdata); end
    model_access(1'b0, 1'b1, 11'd3, 16'h1234, 2'b01);
    drive_cpu(1'b0, 1'b1, 11'd3, 16'h1234, 2'b01);
    model_access(1'b1, 1'b0, 11'd3, '0, '0);
    drive_cpu(1'b1, 1'b0, 11'd3, '0, '0);
    checks++; if (o_rdata !== 16'hAB34) begin errors++; $display("FAIL byte_lo got %h exp AB34", o_rdata); end
    model_access(1'b0, 1'b1, 11'd3, 16'hFFFF, 2'b00);
    drive_cpu(1'b0, 1'b1, 11'd3, 16'hFFFF, 2'b00);
    model_access(1'b1, 1'b0, 11'd3, '0, '0);
    drive_cpu(1'b1, 1'b0, 11'd3, '0, '0);
    checks++; if (o_rdata !== 16'hAB34) begin errors++; $display("FAIL byte_none got %h exp AB34", o_rdata); end
  endtask

  task automatic test_read_first;
    model_access(1'b1, 1'b1, 11'd7, 16'hBEEF, 2'b11);
    drive_cpu(1'b1, 1'b1, 11'd7, 16'hBEEF, 2'b11);
    checks++; if (o_rdata !== 16'h0007) begin errors++; $display("FAIL read_first_old got %h exp 0007", o_rdata); end
    model_access(1'b1, 1'b0, 11'd7, '0, '0);
    drive_cpu(1'b1, 1'b0, 11'd7, '0, '0);
    checks++; if (o_rdata !== 16'hBEEF) begin errors++; $display("FAIL read_first_new got %h exp BEEF", o_rdata); end
  endtask

  task automatic test_range;
    model_access(1'b0, 1'b1, 11'd600, 16'h5555, 2'b11);
    drive_cpu(1'b0, 1'b1, 11'd600, 16'h5555, 2'b11);
    checks++; if (o_addr_err !== 1'b1) begin errors++; $display("FAIL range_wr_err got %b exp 1", o_addr_err); end
    checks++; if (o_rdata !== exp_rdata) begin errors++; $display("FAIL range_wr_hold got %h exp %h", o_rdata, exp_rdata); end
    model_access(1'b0, 1'b0, '0, '0, '0);
    drive_cpu(1'b0, 1'b0, '0, '0, '0);
    checks++; if (o_addr_err !== 1'b0) begin errors++; $display("FAIL range_err_pulse got %b exp 0", o_addr_err); end
    model_access(1'b1, 1'b0, 11'd600, '0, '0);
    drive_cpu(1'b1, 1'b0, 11'd600, '0, '0);
    checks++; if (o_rdata !== 16'h0000) begin errors++; $display("FAIL range_rd_zero got %h exp 0000", o_rdata); end
    checks++; if (o_addr_err !== 1'b1) begin errors++; $display("FAIL range_rd_err got %b exp 1", o_addr_err); end
  endtask

  task automatic test_random;
    logic          rd, wr;
    logic [NA-1:0] addr;
    logic [ND-1:0] wd;
    logic [NB-1:0] be;
    for (int i = 0; i < 300; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       addr = NA'($urandom_range(NC, 2**NA - 1));
        1, 2:    addr = NA'($urandom_range(NC - 4, NC - 1));
        default: addr = NA'($urandom_range(0, 15));
      endcase
      wd = ND'($urandom);
      be = NB'($urandom_range(0, 3));
      model_access(rd, wr, addr, wd, be);
      drive_cpu(rd, wr, addr, wd, be);
      checks++; if (o_rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata[%0d] got %h exp %h", i, o_rdata, exp_rdata); end
      checks++; if (o_addr_err !== exp_err) begin errors++; $display("FAIL rand_err[%0d] got %b exp %b", i, o_addr_err, exp_err); end
    end
  endtask

  task automatic test_dump;
    int   n, stall, done_cnt;
    logic v, finished;
    n = 0; stall = 0; done_cnt = 0; finished = 1'b0;
    @(negedge i_clk);
    i_dump_start = 1'b1; i_dump_ready = 1'b0;
    @(posedge i_clk);
    #1;
    i_dump_start = 1'b0;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL dump_busy_start got %b exp 1", o_busy); end
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge i_clk);
      i_rd = 1'b0; i_wr = 1'b0; i_dump_start = 1'b0;
      if (cyc == 15) begin i_rd = 1'b1; i_wr = 1'b1; i_addr = 11'd10; i_wdata = 16'hFFFF; i_be = '1; end
      if (cyc == 16) begin i_rd = 1'b1; i_addr = 11'd700; end
      if (cyc == 17) i_dump_start = 1'b1;
      checks++; if (o_rdata !== exp_rdata) begin errors++; $display("FAIL dump_rdata_hold got %h exp %h", o_rdata, exp_rdata); end
      checks++; if (o_addr_err !== 1'b0) begin errors++; $display("FAIL dump_no_err got %b exp 0", o_addr_err); end
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL dump_busy got %b exp 1 at word %0d", o_busy, n); end
      if (o_dump_done) begin
        done_cnt++;
        finished = 1'b1;
      end
      v = o_dump_valid;
      if (v) begin
        checks++; if (o_dump_addr !== NA'(n)) begin errors++; $display("FAIL dump_addr got %h exp %h", o_dump_addr, NA'(n)); end
        checks++; if (o_dump_data !== model_mem[NA'(n)]) begin errors++; $display("FAIL dump_data[%0d] got %h exp %h", n, o_dump_data, model_mem[NA'(n)]); end
        if (n == 0 && stall < 3) begin
          i_dump_ready = 1'b0;
          stall++;
        end else begin
          i_dump_ready = ($urandom_range(0, 3) != 0);
        end
      end else begin
        i_dump_ready = 1'($urandom_range(0, 1));
      end
      @(posedge i_clk);
      if (v && i_dump_ready) n++;
    end
    checks++; if (!finished) begin errors++; $display("FAIL dump_timeout got %0d words exp %0d", n, NC); end
    checks++; if (n !== NC) begin errors++; $display("FAIL dump_count got %0d exp %0d", n, NC); end
    @(negedge i_clk);
    i_dump_ready = 1'b0;
    if (o_dump_done) done_cnt++;
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL dump_done_pulses got %0d exp 1", done_cnt); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL dump_idle_busy got %b exp 0", o_busy); end
    model_access(1'b1, 1'b0, 11'd10, '0, '0);
    drive_cpu(1'b1, 1'b0, 11'd10, '0, '0);
    checks++; if (o_rdata !== exp_rdata) begin errors++; $display("FAIL dump_ignored_wr got %h exp %h", o_rdata, exp_rdata); end
  endtask

  task automatic test_reset_mid_dump;
    int   n, cyc;
    logic v, seen;
    n = 0;
    @(negedge i_clk);
    i_dump_start = 1'b1; i_dump_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_dump_start = 1'b0;
    for (cyc = 0; cyc < 100 && n < 10; cyc++) begin
      @(negedge i_clk);
      v = o_dump_valid;
      @(posedge i_clk);
      if (v) n++;
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL mid_progress got %0d exp 10", n); end
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    exp_rdata = '0;
    checks++; if (o_busy !== 1'b0)       begin errors++; $display("FAIL mid_busy got %b exp 0", o_busy); end
    checks++; if (o_dump_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", o_dump_valid); end
    checks++; if (o_dump_addr !== '0)    begin errors++; $display("FAIL mid_daddr got %h exp 0", o_dump_addr); end
    checks++; if (o_rdata !== exp_rdata) begin errors++; $display("FAIL mid_rdata got %h exp %h", o_rdata, exp_rdata); end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if (o_dump_done || o_busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_done got %b exp 0", seen); end
    @(negedge i_clk);
    i_dump_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_dump_start = 1'b0;
    seen = 1'b0;
    for (cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge i_clk);
      seen = o_dump_valid;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL restart_valid got %b exp 1", seen); end
    checks++; if (o_dump_addr !== '0) begin errors++; $display("FAIL restart_addr got %h exp 0", o_dump_addr); end
    checks++; if (o_dump_data !== model_mem[0]) begin errors++; $display("FAIL restart_data got %h exp %h", o_dump_data, model_mem[0]); end
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    exp_rdata = '0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int k = 0; k < 2**NA; k++) model_mem[k] = ND'(k);
    exp_rdata = '0; exp_err = 1'b0;
    i_reset = 1'b1; i_rd = 1'b0; i_wr = 1'b0; i_addr = '0; i_wdata = '0; i_be = '0;
    i_dump_start = 1'b0; i_dump_ready = 1'b0;
    test_reset();
    test_powerup();
    test_byte_write();
    test_read_first();
    test_range();
    test_random();
    test_dump();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
